// File: rtl/led_mode_ctrl.sv
// Push-button LED mode controller: synchronizer, debounce, press/long-press detect,
// OFF/ON/BLINK/CHASE mode FSM and a registered, glitch-free LED pattern generator.
module led_mode_ctrl #(
   parameter int unsigned DEB_CYCLES  = 400000,
   parameter int unsigned TICK_CYCLES = 4000000,
   parameter int unsigned BLINK_TICKS = 5,
   parameter int unsigned LONG_CYCLES = 80000000
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       btn,
   output logic [3:0] led,
   output logic [1:0] mode
);

   localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
   localparam int unsigned TICK_W  = $clog2(TICK_CYCLES + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
   localparam int unsigned LONG_W  = $clog2(LONG_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_ON    = 2'd1,
      ST_BLINK = 2'd2,
      ST_CHASE = 2'd3
   } state_e;

   logic [2:0]         sync_q;
   logic               btn_stable_q, btn_stable_d;
   logic               stable_dly_q;
   logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic [1:0]         fill_q, fill_d;
   logic               armed_q, armed_d;
   logic [LONG_W-1:0]  long_cnt_q, long_cnt_d;
   logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_off_q, blink_off_d;
   logic [1:0]         chase_idx_q, chase_idx_d;
   state_e             state_q, state_d;
   logic [3:0]         led_q, led_d;

   logic press_c;
   logic long_c;
   logic mode_chg_c;
   logic tick_wrap_c;
   logic tick_c;

   // Debounce: adopt the synchronized level only after DEB_CYCLES consecutive differing cycles
   always_comb begin
      deb_cnt_d    = '0;
      btn_stable_d = btn_stable_q;
      if (sync_q[2] != btn_stable_q) begin
         if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            btn_stable_d = sync_q[2];
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   // Arm presses only once a released button has been seen after reset
   always_comb begin
      fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
      armed_d = armed_q | ((fill_q == 2'd3) & sync_q[2]);
   end

   assign press_c = armed_q & stable_dly_q & ~btn_stable_q;
   assign long_c  = ~btn_stable_q & (long_cnt_q == LONG_W'(LONG_CYCLES - 1));

   always_comb begin
      long_cnt_d = long_cnt_q;
      if (btn_stable_q) begin
         long_cnt_d = '0;
      end else if (long_cnt_q != LONG_W'(LONG_CYCLES)) begin
         long_cnt_d = long_cnt_q + LONG_W'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: long press wins over a coincident press pulse
   always_comb begin
      state_d = state_q;
      if (long_c) begin
         state_d = ST_OFF;
      end else if (press_c) begin
         case (state_q)
            ST_OFF:   state_d = ST_ON;
            ST_ON:    state_d = ST_BLINK;
            ST_BLINK: state_d = ST_CHASE;
            default:  state_d = ST_OFF;
         endcase
      end
   end

   assign mode_chg_c  = (state_d != state_q);
   assign tick_wrap_c = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
   assign tick_c      = tick_wrap_c & ~mode_chg_c;

   // Timebase and pattern sub-state, restarted on every mode change
   always_comb begin
      tick_cnt_d  = tick_wrap_c ? '0 : tick_cnt_q + TICK_W'(1);
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      chase_idx_d = chase_idx_q;
      if (mode_chg_c) begin
         tick_cnt_d  = '0;
         blink_cnt_d = '0;
         blink_off_d = 1'b0;
         chase_idx_d = 2'd0;
      end else if (tick_c) begin
         if (state_q == ST_BLINK) begin
            if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
               blink_cnt_d = '0;
               blink_off_d = ~blink_off_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
         end
         if (state_q == ST_CHASE) begin
            chase_idx_d = chase_idx_q + 2'd1;
         end
      end
   end

   // FSM output: LED pattern for the upcoming state, registered alongside it
   always_comb begin
      led_d = 4'hF;
      case (state_d)
         ST_OFF:   led_d = 4'hF;
         ST_ON:    led_d = 4'h0;
         ST_BLINK: led_d = blink_off_d ? 4'hF : 4'h0;
         default:  led_d = ~(4'b0001 << chase_idx_d);
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sync_q       <= 3'b111;
         btn_stable_q <= 1'b1;
         stable_dly_q <= 1'b1;
         deb_cnt_q    <= '0;
         fill_q       <= 2'd0;
         armed_q      <= 1'b0;
         long_cnt_q   <= '0;
         tick_cnt_q   <= '0;
         blink_cnt_q  <= '0;
         blink_off_q  <= 1'b0;
         chase_idx_q  <= 2'd0;
         led_q        <= 4'hF;
      end else begin
         sync_q       <= {sync_q[1:0], btn};
         btn_stable_q <= btn_stable_d;
         stable_dly_q <= btn_stable_q;
         deb_cnt_q    <= deb_cnt_d;
         fill_q       <= fill_d;
         armed_q      <= armed_d;
         long_cnt_q   <= long_cnt_d;
         tick_cnt_q   <= tick_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_off_q  <= blink_off_d;
         chase_idx_q  <= chase_idx_d;
         led_q        <= led_d;
      end
   end

   assign led  = led_q;
   assign mode = state_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with short debounce/tick/long-press parameters.
module tb_led_mode_ctrl;

   localparam int unsigned DEB   = 4;
   localparam int unsigned TICK  = 8;
   localparam int unsigned BLINK = 2;
   localparam int unsigned LONG  = 64;

   logic       clk = 1'b0;
   logic       rstb;
   logic       btn;
   logic [3:0] led;
   logic [1:0] mode;

   int         checks   = 0;
   int         failures = 0;
   logic [1:0] exp_q[$];
   logic [1:0] prev_mode;

   led_mode_ctrl #(
      .DEB_CYCLES (DEB),
      .TICK_CYCLES(TICK),
      .BLINK_TICKS(BLINK),
      .LONG_CYCLES(LONG)
   ) dut (
      .clk (clk),
      .rstb(rstb),
      .btn (btn),
      .led (led),
      .mode(mode)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // LED pattern expected on the first cycle of each mode
   function automatic logic [3:0] entry_led(input logic [1:0] m);
      case (m)
         2'd0:    return 4'hF;
         2'd1:    return 4'h0;
         2'd2:    return 4'h0;
         default: return 4'hE;
      endcase
   endfunction

   // Scoreboard: every mode change outside reset must match the next queued expectation
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (rstb === 1'b1 && mode !== prev_mode) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected mode=%0d prev=%0d required=no change", mode, prev_mode);
            end else begin
               e = exp_q.pop_front();
               if (mode !== e || led !== entry_led(e)) begin
                  failures++;
                  $display("FAIL sb_mode mode=%0d led=%h required mode=%0d led=%h",
                           mode, led, e, entry_led(e));
               end
            end
         end
         prev_mode = mode;
      end
   end

   task automatic wait_mode(input logic [1:0] m, input int bound, output int n);
      n = 0;
      while (mode !== m && n < bound) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic press(input int hold);
      btn = 1'b0;
      repeat (hold) @(negedge clk);
      btn = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_reset;
      rstb = 1'b1;
      btn  = 1'b0;
      #1;
      rstb = 1'b0;
      #1;
      checks++;
      if (led !== 4'hF || mode !== 2'd0) begin
         failures++;
         $display("FAIL reset_async led=%h mode=%0d required led=F mode=0", led, mode);
      end
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (mode !== 2'd0 || led !== 4'hF) begin
         failures++;
         $display("FAIL reset_btn_held mode=%0d led=%h required mode=0 led=F", mode, led);
      end
      btn = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (mode !== 2'd0) begin
         failures++;
         $display("FAIL reset_release mode=%0d required 0", mode);
      end
   endtask

   task automatic test_debounce;
      int n;
      repeat (3) begin
         btn = 1'b0;
         repeat (3) @(negedge clk);
         btn = 1'b1;
         repeat (8) @(negedge clk);
      end
      checks++;
      if (mode !== 2'd0) begin
         failures++;
         $display("FAIL deb_glitch mode=%0d required 0", mode);
      end
      exp_q.push_back(2'd1);
      btn = 1'b0;
      wait_mode(2'd1, 12, n);
      checks++;
      if (n < 8 || n > 10) begin
         failures++;
         $display("FAIL deb_latency cycles=%0d required 8..10", n);
      end
      checks++;
      if (led !== 4'h0) begin
         failures++;
         $display("FAIL deb_led led=%h required 0", led);
      end
      repeat (4) @(negedge clk);
      btn = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_mode_walk;
      logic [1:0] m;
      rstb = 1'b0;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (mode !== 2'd0) begin
         failures++;
         $display("FAIL walk_reset mode=%0d required 0", mode);
      end
      for (int i = 0; i < 4; i++) begin
         m = 2'((i + 1) % 4);
         exp_q.push_back(m);
         press(10);
         checks++;
         if (mode !== m) begin
            failures++;
            $display("FAIL walk_step%0d mode=%0d required %0d", i, mode, m);
         end
      end
      checks++;
      if (led !== 4'hF) begin
         failures++;
         $display("FAIL walk_off_led led=%h required F", led);
      end
   endtask

   task automatic test_blink;
      int         n;
      logic [3:0] exp_led;
      exp_q.push_back(2'd1);
      press(10);
      exp_q.push_back(2'd2);
      btn = 1'b0;
      wait_mode(2'd2, 12, n);
      checks++;
      if (n >= 12) begin
         failures++;
         $display("FAIL blink_enter mode=%0d required 2", mode);
      end
      for (int k = 0; k < 64; k++) begin
         exp_led = (((k / 16) % 2) == 0) ? 4'h0 : 4'hF;
         checks++;
         if (led !== exp_led) begin
            failures++;
            $display("FAIL blink_cycle%0d led=%h required %h", k, led, exp_led);
         end
         if (k == 6) btn = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_chase;
      int         n;
      logic [3:0] exp_led;
      exp_q.push_back(2'd3);
      btn = 1'b0;
      wait_mode(2'd3, 12, n);
      checks++;
      if (n >= 12) begin
         failures++;
         $display("FAIL chase_enter mode=%0d required 3", mode);
      end
      for (int k = 0; k < 40; k++) begin
         exp_led = ~(4'b0001 << ((k / 8) % 4));
         checks++;
         if (led !== exp_led) begin
            failures++;
            $display("FAIL chase_cycle%0d led=%h required %h", k, led, exp_led);
         end
         if (k == 6) btn = 1'b1;
         @(negedge clk);
      end
      exp_q.push_back(2'd0);
      press(10);
      checks++;
      if (mode !== 2'd0 || led !== 4'hF) begin
         failures++;
         $display("FAIL chase_exit mode=%0d led=%h required mode=0 led=F", mode, led);
      end
   endtask

   task automatic test_long_press;
      int n1;
      int n2;
      exp_q.push_back(2'd1);
      press(10);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd0);
      btn = 1'b0;
      wait_mode(2'd2, 12, n1);
      checks++;
      if (n1 >= 12) begin
         failures++;
         $display("FAIL long_press_step mode=%0d required 2", mode);
      end
      wait_mode(2'd0, 80, n2);
      checks++;
      if (n2 < 62 || n2 > 66) begin
         failures++;
         $display("FAIL long_force cycles=%0d mode=%0d required 62..66 to mode 0", n2, mode);
      end
      repeat (80 - n1 - n2) @(negedge clk);
      btn = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (mode !== 2'd0 || led !== 4'hF) begin
         failures++;
         $display("FAIL long_release mode=%0d led=%h required mode=0 led=F", mode, led);
      end
   endtask

   task automatic test_reset_mid;
      for (int t = 2; t <= 3; t++) begin
         for (int p = 1; p <= t; p++) begin
            exp_q.push_back(2'(p));
            press(10);
         end
         repeat (5) @(negedge clk);
         #2;
         rstb = 1'b0;
         #1;
         checks++;
         if (led !== 4'hF || mode !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_mode%0d led=%h mode=%0d required led=F mode=0", t, led, mode);
         end
         repeat (2) @(negedge clk);
         rstb = 1'b1;
         repeat (20) @(negedge clk);
         checks++;
         if (mode !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_after%0d mode=%0d required 0", t, mode);
         end
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_mode_walk();
      test_blink();
      test_chase();
      test_long_press();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_pending left=%0d required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
